// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer and its command FIFO.
package alu_pkg;
    localparam int OPND_W = 8;
    localparam int RES_W  = 16;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_NOP = 3'b000;
    localparam alu_op_t OP_ADD = 3'b001;
    localparam alu_op_t OP_MUL = 3'b010;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;

    // 19-bit queued command, packed as {opcode, a, b}
    typedef struct packed {
        alu_op_t           opcode;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap naturally because DEPTH is a power of 2.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  cmd_t                     wdata,
    input  logic                     pop,
    output cmd_t                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues queued ALU commands one at a time: start pulse, wait for done (or watchdog), then respond.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_opcode,
    input  logic [OPND_W-1:0]        cmd_a,
    input  logic [OPND_W-1:0]        cmd_b,
    output logic [OPND_W-1:0]        alu_a,
    output logic [OPND_W-1:0]        alu_b,
    output logic [2:0]               alu_opcode,
    output logic                     alu_start,
    input  logic [RES_W-1:0]         alu_result,
    input  logic                     alu_done,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RES_W-1:0]         rsp_result,
    output logic [2:0]               rsp_opcode,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int WDW = $clog2(TIMEOUT);

    seq_state_t          state_q, state_d;
    logic [WDW-1:0]      wd_q, wd_d;
    logic [OPND_W-1:0]   a_q, a_d, b_q, b_d;
    alu_op_t             op_q, op_d, rop_q, rop_d;
    logic [RES_W-1:0]    rres_q, rres_d;
    logic                rto_q, rto_d;

    cmd_t                head;
    logic                fifo_full, fifo_empty, fifo_pop;

    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .wdata ({cmd_opcode, cmd_a, cmd_b}),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rres_d  = rres_q;
        rop_d   = rop_q;
        rto_d   = rto_q;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                a_d     = head.a;
                b_d     = head.b;
                op_d    = head.opcode;
                state_d = ISSUE;
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done wins over the watchdog when both land in the same cycle
                if (alu_done) begin
                    rres_d  = alu_result;
                    rop_d   = op_q;
                    rto_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    rres_d  = '0;
                    rop_d   = op_q;
                    rto_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_NOP;
            rres_q  <= '0;
            rop_q   <= OP_NOP;
            rto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rres_q  <= rres_d;
            rop_q   <= rop_d;
            rto_q   <= rto_d;
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_opcode  = op_q;
    assign alu_start   = (state_q == ISSUE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_result  = rres_q;
    assign rsp_opcode  = rop_q;
    assign rsp_timeout = rto_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: vector table for single commands plus hand sequences for FIFO, watchdog, stray done and reset.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode = '0;
    logic [7:0]  cmd_a = '0, cmd_b = '0;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic        alu_start;
    logic [15:0] alu_result;
    logic        alu_done;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_opcode;
    logic        rsp_timeout;
    logic        busy;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
        .alu_result(alu_result), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_opcode(rsp_opcode), .rsp_timeout(rsp_timeout),
        .busy(busy), .fifo_count(fifo_count)
    );

    // ALU model: done_dly cycles after the start cycle it pulses done; 0 means never
    int          done_dly = 1;
    int          cnt = 0;
    int          start_cnt = 0;
    int          hold_err = 0;
    logic        done_m = 1'b0, stray_done = 1'b0;
    logic [15:0] res_m = '0;
    logic [7:0]  ca = '0, cb = '0;
    logic [2:0]  cop = '0;
    assign alu_done   = done_m | stray_done;
    assign alu_result = res_m;

    always @(negedge clk) begin
        done_m = 1'b0;
        if (cnt > 0) begin
            if (alu_a !== ca || alu_b !== cb || alu_opcode !== cop) hold_err++;
            cnt--;
            if (cnt == 0) begin
                done_m = 1'b1;
                case (cop)
                    OP_ADD:  res_m = 16'(ca) + 16'(cb);
                    OP_MUL:  res_m = 16'(ca) * 16'(cb);
                    default: res_m = 16'h0000;
                endcase
            end
        end
        if (alu_start) begin
            start_cnt++;
            ca = alu_a; cb = alu_b; cop = alu_opcode;
            cnt = done_dly;
        end
    end

    // response log, sampled on the handshake edge
    logic [15:0] log_res[$];
    logic        log_to[$];
    always @(posedge clk) begin
        if (rsp_valid && rsp_ready) begin
            log_res.push_back(rsp_result);
            log_to.push_back(rsp_timeout);
        end
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a, b;
        int          dly;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, s0, h0, L0;
        logic [5:0] acc;

        vecs[0] = '{OP_ADD, 8'h2A, 8'h15, 1, 16'h003F};
        vecs[1] = '{OP_MUL, 8'hFF, 8'hFF, 8, 16'hFE01};
        vecs[2] = '{OP_ADD, 8'hFF, 8'hFF, 2, 16'h01FE};
        vecs[3] = '{OP_MUL, 8'h12, 8'h34, 1, 16'h03A8};
        vecs[4] = '{OP_NOP, 8'h55, 8'hAA, 4, 16'h0000};
        vecs[5] = '{OP_ADD, 8'h00, 8'h00, 1, 16'h0000};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset cmd_ready", 32'(cmd_ready), 1);
        check("reset fifo_count", 32'(fifo_count), 0);
        check("reset busy", 32'(busy), 0);
        check("reset rsp_valid", 32'(rsp_valid), 0);
        check("reset alu_start", 32'(alu_start), 0);
        check("reset alu_a/b/op", {13'd0, alu_opcode, alu_a, alu_b}, 0);
        check("reset rsp_result", 32'(rsp_result), 0);

        // single commands; latency from acceptance cycle to rsp_valid is 3 + done delay
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            done_dly = vecs[i].dly;
            cmd_valid = 1'b1; cmd_opcode = vecs[i].op; cmd_a = vecs[i].a; cmd_b = vecs[i].b;
            s0 = start_cnt; h0 = hold_err; n = 0;
            do begin
                @(negedge clk);
                cmd_valid = 1'b0;
                n++;
            end while (!rsp_valid && n < 100);
            check($sformatf("vec%0d result", i), 32'(rsp_result), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d opcode", i), 32'(rsp_opcode), 32'(vecs[i].op));
            check($sformatf("vec%0d timeout", i), 32'(rsp_timeout), 0);
            check($sformatf("vec%0d latency", i), n, 3 + vecs[i].dly);
            @(negedge clk);
            check($sformatf("vec%0d start pulses", i), start_cnt - s0, 1);
            check($sformatf("vec%0d operand hold", i), hold_err - h0, 0);
            check($sformatf("vec%0d rsp_valid drop", i), 32'(rsp_valid), 0);
        end

        // backpressure: six back-to-back pushes with rsp_ready low
        done_dly = 1; rsp_ready = 1'b0;
        L0 = log_res.size();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_a = 8'(i + 1); cmd_b = 8'(i * 16);
            acc[i] = cmd_ready;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("full accept mask", 32'(acc), 32'h1F);
        check("full fifo_count", 32'(fifo_count), 4);
        check("full cmd_ready", 32'(cmd_ready), 0);
        check("full rsp_valid", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        n = 0;
        while (log_res.size() < L0 + 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("full response count", log_res.size() - L0, 5);
        for (int i = 0; i < 5; i++)
            if (L0 + i < log_res.size())
                check($sformatf("full rsp%0d", i), 32'(log_res[L0 + i]), (i + 1) + i * 16);
        repeat (3) @(negedge clk);

        // watchdog: first command never completes, second one does
        done_dly = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_a = 8'd1; cmd_b = 8'd2;
        @(negedge clk);
        cmd_a = 8'd3; cmd_b = 8'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!alu_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout start seen", 32'(alu_start), 1);
        n = 0;
        do begin
            @(negedge clk);
            done_dly = 1;
            if (!rsp_valid) n++;
        end while (!rsp_valid && n < 100);
        check("timeout wait cycles", n, 32);
        check("timeout flag", 32'(rsp_timeout), 1);
        check("timeout result", 32'(rsp_result), 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        check("post-timeout result", 32'(rsp_result), 16'h0007);
        check("post-timeout flag", 32'(rsp_timeout), 0);
        @(negedge clk);

        // stray done in IDLE produces nothing
        L0 = log_res.size();
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check("stray idle no rsp", log_res.size() - L0, 0);
        check("stray idle busy", 32'(busy), 0);

        // stray done in the ISSUE cycle is ignored; real done 3 cycles after start
        done_dly = 3;
        cmd_valid = 1'b1; cmd_opcode = OP_MUL; cmd_a = 8'h03; cmd_b = 8'h05;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!alu_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        stray_done = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            stray_done = 1'b0;
            n++;
        end while (!rsp_valid && n < 50);
        check("stray issue latency", n, 4);
        check("stray issue result", 32'(rsp_result), 16'h000F);
        @(negedge clk);

        // reset while waiting with two commands queued
        done_dly = 0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_a = 8'(i); cmd_b = 8'(i);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 32'(busy), 1);
        check("pre-reset fifo_count", 32'(fifo_count), 2);
        L0 = log_res.size();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid-reset busy", 32'(busy), 0);
        check("mid-reset fifo_count", 32'(fifo_count), 0);
        check("mid-reset rsp_valid", 32'(rsp_valid), 0);
        check("mid-reset alu_start", 32'(alu_start), 0);
        repeat (40) @(negedge clk);
        check("mid-reset no responses", log_res.size() - L0, 0);
        check("mid-reset stays idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
